// File: rtl/cpx_rtn_decode_pkg.sv
// Shared CPX return-bus field map, type codes and decoded-field struct
// for the CPX return decode stage and its scoreboard.
package cpx_rtn_decode_pkg;

  localparam int CPX_VLD    = 144;
  localparam int CPX_RTN_HI = 143;
  localparam int CPX_RTN_LO = 140;
  localparam int CPX_NC     = 136;
  localparam int CPX_TID_HI = 135;
  localparam int CPX_TID_LO = 134;
  localparam int CPX_WV     = 133;

  localparam int TID_W = CPX_TID_HI - CPX_TID_LO + 1;

  localparam logic [3:0] LD_RTN = 4'b0000;
  localparam logic [4:0] PCX_LD = 5'b00000;

  typedef struct packed {
    logic             vld;
    logic [3:0]       rtntype;
    logic             nc;
    logic [TID_W-1:0] tid;
    logic             wv;
  } cpx_fields_t;

endpackage

// File: rtl/nc_ld_cnt.sv
// Saturating up/down counter of outstanding non-cacheable loads for one
// thread; flags a decrement at zero or an increment at the ceiling.
module nc_ld_cnt #(
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst_l,
  input  logic inc,
  input  logic dec,
  output logic nonzero,
  output logic underflow,
  output logic overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // NOTE: every output of this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    cnt_d     = cnt_q;
    underflow = 1'b0;
    overflow  = 1'b0;
    if (inc && !dec) begin
      if (cnt_q == CNT_MAX) overflow = 1'b1;
      else                  cnt_d    = cnt_q + CNT_W'(1);
    end else if (dec && !inc) begin
      if (cnt_q == '0) underflow = 1'b1;
      else             cnt_d     = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt_q   <= '0;
      nonzero <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      nonzero <= (cnt_d != '0);
    end
  end

endmodule

// File: rtl/cpx_rtn_decode.sv
// Two-stage CPX return capture and decode for one core, plus a per-thread
// scoreboard of outstanding non-cacheable loads with sticky error flags.
module cpx_rtn_decode
  import cpx_rtn_decode_pkg::*;
#(
  parameter int CPX_W   = 145,
  parameter int NTHR    = 4,
  parameter int CNT_W   = 3,
  parameter int CORE_ID = 0
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic [CPX_W-1:0] cpx_pkt,
  input  logic             pcx_req_vld,
  input  logic [4:0]       pcx_rqtype,
  input  logic             pcx_nc,
  input  logic [TID_W-1:0] pcx_tid,
  output logic             cpxpkt_vld,
  output logic [3:0]       cpxpkt_rtntype,
  output logic             nc,
  output logic             wv,
  output logic [2:0]       coreid,
  output logic [NTHR-1:0]  nc_outstanding,
  output logic             err_unmatched,
  output logic             err_overflow
);

  cpx_fields_t cx_d;
  cpx_fields_t cx_q;
  cpx_fields_t cx2_q;

  assign cx_d = {cpx_pkt[CPX_VLD],
                 cpx_pkt[CPX_RTN_HI:CPX_RTN_LO],
                 cpx_pkt[CPX_NC],
                 cpx_pkt[CPX_TID_HI:CPX_TID_LO],
                 cpx_pkt[CPX_WV]};

  // Remaining payload bits and the CX2 thread id are not needed downstream.
  logic unused_bits;
  assign unused_bits = ^{cpx_pkt, cx2_q.tid};

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cx_q  <= '0;
      cx2_q <= '0;
    end else begin
      cx_q  <= cx_d;
      cx2_q <= cx_q;
    end
  end

  // Fields are forced to zero whenever the CX2 packet is not valid.
  assign cpxpkt_vld     = cx2_q.vld;
  assign cpxpkt_rtntype = cx2_q.vld ? cx2_q.rtntype : 4'b0000;
  assign nc             = cx2_q.vld & cx2_q.nc;
  assign wv             = cx2_q.vld & cx2_q.wv;
  assign coreid         = 3'(CORE_ID);

  logic            pcx_ld_nc;
  logic            cx_ld_nc;
  logic [NTHR-1:0] inc;
  logic [NTHR-1:0] dec;
  logic [NTHR-1:0] underflow;
  logic [NTHR-1:0] overflow;

  assign pcx_ld_nc = pcx_req_vld && (pcx_rqtype == PCX_LD) && pcx_nc;
  assign cx_ld_nc  = cx_q.vld && (cx_q.rtntype == LD_RTN) && cx_q.nc;

  for (genvar t = 0; t < NTHR; t++) begin : g_thr
    assign inc[t] = pcx_ld_nc && (pcx_tid  == TID_W'(t));
    assign dec[t] = cx_ld_nc  && (cx_q.tid == TID_W'(t));

    nc_ld_cnt #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk      (clk),
      .rst_l    (rst_l),
      .inc      (inc[t]),
      .dec      (dec[t]),
      .nonzero  (nc_outstanding[t]),
      .underflow(underflow[t]),
      .overflow (overflow[t])
    );
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      err_unmatched <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      err_unmatched <= err_unmatched | (|underflow);
      err_overflow  <= err_overflow  | (|overflow);
    end
  end

endmodule
